// File: rtl/lcd_64_to_32_bits_dfa_state_arbiter.sv
// Two-requester round-robin arbiter in front of a DFA state RAM (one write port, one read port).
// Accepted reads are tracked by a {valid, id} pipe matched to the RAM read latency.
module lcd_64_to_32_bits_dfa_state_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 1,
  parameter int unsigned DATA_WIDTH    = 3,
  parameter int unsigned RD_LATENCY    = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,

  input  logic [ADDRESS_WIDTH-1:0] r0_address,
  input  logic [DATA_WIDTH-1:0]    r0_writedata,
  input  logic                     r0_write,
  input  logic                     r0_read,
  output logic                     r0_waitrequest,
  output logic [DATA_WIDTH-1:0]    r0_readdata,
  output logic                     r0_readdatavalid,

  input  logic [ADDRESS_WIDTH-1:0] r1_address,
  input  logic [DATA_WIDTH-1:0]    r1_writedata,
  input  logic                     r1_write,
  input  logic                     r1_read,
  output logic                     r1_waitrequest,
  output logic [DATA_WIDTH-1:0]    r1_readdata,
  output logic                     r1_readdatavalid,

  output logic [ADDRESS_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0]    wr_writedata,
  output logic                     wr_write,
  input  logic                     wr_waitrequest,

  output logic [ADDRESS_WIDTH-1:0] rd0_address,
  input  logic [DATA_WIDTH-1:0]    rd0_readdata
);

  logic                     act0;
  logic                     act1;
  logic                     grant_any;
  logic                     grant_id;
  logic                     grant_read;
  logic                     grant_write;
  logic [ADDRESS_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0]    grant_data;
  logic                     accept;
  logic                     pipe_in_valid;

  logic                     last_grant_q;
  logic                     last_grant_d;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [RD_LATENCY-1:0]    pipe_valid_q;
  logic [RD_LATENCY-1:0]    pipe_id_q;
  logic                     pipe_out_valid;

  always_comb begin
    act0      = r0_read | r0_write;
    act1      = r1_read | r1_write;
    grant_any = act0 | act1;

    grant_id = 1'b0;
    if (act0 && act1) begin
      grant_id = ~last_grant_q;
    end else if (act1) begin
      grant_id = 1'b1;
    end

    grant_read  = grant_id ? r1_read      : r0_read;
    grant_write = grant_id ? r1_write     : r0_write;
    grant_addr  = grant_id ? r1_address   : r0_address;
    grant_data  = grant_id ? r1_writedata : r0_writedata;

    // Nothing is accepted while the RAM is busy or the block is held in reset.
    accept = grant_any & ~wr_waitrequest & reset_n;

    addr_d        = accept ? grant_addr : addr_q;
    last_grant_d  = accept ? grant_id   : last_grant_q;
    pipe_in_valid = accept & grant_read;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      pipe_valid_q <= '0;
      pipe_id_q    <= '0;
    end else begin
      last_grant_q    <= last_grant_d;
      addr_q          <= addr_d;
      pipe_valid_q[0] <= pipe_in_valid;
      pipe_id_q[0]    <= grant_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_id_q[i]    <= pipe_id_q[i-1];
      end
    end
  end

  assign r0_waitrequest = act0 & ~(accept & ~grant_id);
  assign r1_waitrequest = act1 & ~(accept & grant_id);

  assign wr_address   = addr_d;
  assign rd0_address  = addr_d;
  assign wr_writedata = grant_data;
  assign wr_write     = accept & grant_write;

  // Gating with reset_n drops any read still in flight when reset arrives.
  assign pipe_out_valid   = pipe_valid_q[RD_LATENCY-1] & reset_n;
  assign r0_readdatavalid = pipe_out_valid & ~pipe_id_q[RD_LATENCY-1];
  assign r1_readdatavalid = pipe_out_valid & pipe_id_q[RD_LATENCY-1];
  assign r0_readdata      = rd0_readdata;
  assign r1_readdata      = rd0_readdata;

endmodule

// File: tb/tb_lcd_64_to_32_bits_dfa_state_arbiter.sv
// Scoreboard bench for the state-RAM arbiter; a small lookahead RAM model sits on the RAM ports.
module tb_lcd_64_to_32_bits_dfa_state_arbiter;
  localparam int AW  = 1;
  localparam int DW  = 3;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] r0_address, r1_address, wr_address, rd0_address;
  logic [DW-1:0] r0_writedata, r1_writedata, r0_readdata, r1_readdata;
  logic [DW-1:0] wr_writedata, rd0_readdata;
  logic          r0_write, r0_read, r0_waitrequest, r0_readdatavalid;
  logic          r1_write, r1_read, r1_waitrequest, r1_readdatavalid;
  logic          wr_write, wr_waitrequest;

  always #5 clk = ~clk;

  lcd_64_to_32_bits_dfa_state_arbiter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_address(r0_address), .r0_writedata(r0_writedata), .r0_write(r0_write),
    .r0_read(r0_read), .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata),
    .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_writedata(r1_writedata), .r1_write(r1_write),
    .r1_read(r1_read), .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata),
    .r1_readdatavalid(r1_readdatavalid),
    .wr_address(wr_address), .wr_writedata(wr_writedata), .wr_write(wr_write),
    .wr_waitrequest(wr_waitrequest),
    .rd0_address(rd0_address), .rd0_readdata(rd0_readdata)
  );

  // State RAM with write-to-read lookahead, one clock of read latency.
  logic [DW-1:0] mem [2];
  always @(posedge clk) begin
    if (wr_write) mem[wr_address] <= wr_writedata;
    rd0_readdata <= (wr_write && wr_address == rd0_address) ? wr_writedata : mem[rd0_address];
  end

  typedef struct {
    int id;
    int wr;
    int addr;
    int data;
  } acc_t;
  typedef struct {
    int id;
    int data;
  } rd_t;

  acc_t acc_q[$];
  rd_t  rd_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_acc(input int id, input int wr, input int addr, input int data);
    acc_t e;
    e.id = id; e.wr = wr; e.addr = addr; e.data = data;
    acc_q.push_back(e);
  endtask

  task automatic push_rd(input int id, input int data);
    rd_t e;
    e.id = id; e.data = data;
    rd_q.push_back(e);
  endtask

  // Monitor: every accept and every readdatavalid strobe is matched against the queues.
  int   mon_a0, mon_a1, mon_v0, mon_v1;
  acc_t mon_acc;
  rd_t  mon_rd;
  always @(negedge clk) begin
    mon_a0 = int'((r0_read | r0_write) & ~r0_waitrequest);
    mon_a1 = int'((r1_read | r1_write) & ~r1_waitrequest);
    mon_v0 = int'(r0_readdatavalid);
    mon_v1 = int'(r1_readdatavalid);
    if (mon_a0 != 0 || mon_a1 != 0) begin
      check("accepts_per_cycle", mon_a0 + mon_a1, 1);
      check("accept_expected", acc_q.size() > 0 ? 1 : 0, 1);
      if (acc_q.size() > 0) begin
        mon_acc = acc_q.pop_front();
        check("accept_id", mon_a1, mon_acc.id);
        check("wr_write", int'(wr_write), mon_acc.wr);
        check("wr_address", int'(wr_address), mon_acc.addr);
        check("rd0_address", int'(rd0_address), mon_acc.addr);
        if (mon_acc.wr != 0) check("wr_writedata", int'(wr_writedata), mon_acc.data);
      end
    end else begin
      check("idle_wr_write", int'(wr_write), 0);
    end
    if (mon_v0 != 0 || mon_v1 != 0) begin
      check("strobes_per_cycle", mon_v0 + mon_v1, 1);
      check("readdata_expected", rd_q.size() > 0 ? 1 : 0, 1);
      if (rd_q.size() > 0) begin
        mon_rd = rd_q.pop_front();
        check("readdatavalid_id", mon_v1, mon_rd.id);
        check("readdata", mon_v1 != 0 ? int'(r1_readdata) : int'(r0_readdata), mon_rd.data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int rst, input int wwait,
                       input int r0r, input int r0w, input int r0a, input int r0d,
                       input int r1r, input int r1w, input int r1a, input int r1d);
    reset_n        = rst[0];
    wr_waitrequest = wwait[0];
    r0_read        = r0r[0];
    r0_write       = r0w[0];
    r0_address     = AW'(r0a);
    r0_writedata   = DW'(r0d);
    r1_read        = r1r[0];
    r1_write       = r1w[0];
    r1_address     = AW'(r1a);
    r1_writedata   = DW'(r1d);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mem[0] = '0;
    mem[1] = '0;
    rd0_readdata = '0;
    reset_n = 1'b0; wr_waitrequest = 1'b1;
    r0_read = 1'b0; r0_write = 1'b0; r0_address = '0; r0_writedata = '0;
    r1_read = 1'b0; r1_write = 1'b0; r1_address = '0; r1_writedata = '0;

    // Reset with r0 already requesting, then RAM busy for two cycles after release.
    for (int i = 0; i < 2; i++) begin
      cyc(); drive(0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
      check("rst_r0_wait", int'(r0_waitrequest), 1);
      check("rst_wr_write", int'(wr_write), 0);
      check("rst_r0_rdv", int'(r0_readdatavalid), 0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); drive(1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
      check("busy_r0_wait", int'(r0_waitrequest), 1);
      check("busy_wr_write", int'(wr_write), 0);
    end
    cyc(); push_acc(0, 0, 1, 0); push_rd(0, 0); drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    check("first_accept_wait", int'(r0_waitrequest), 0);
    cyc(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("first_read_rdv", int'(r0_readdatavalid), 1);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_held_addr", int'(wr_address), 0);

    // r0 writes 5 to addr0 while r1 reads addr0: r0 first, r1 sees the new value.
    cyc(); push_acc(0, 1, 0, 5); drive(1, 0, 0, 1, 0, 5, 1, 0, 0, 0);
    check("b_r1_wait", int'(r1_waitrequest), 1);
    cyc(); push_acc(1, 0, 0, 0); push_rd(1, 5); drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("b_r1_rdv", int'(r1_readdatavalid), 1);
    check("b_r1_data", int'(r1_readdata), 5);

    // addr1 <= 6, then r0 read+write addr1 with 3; lookahead returns 3.
    cyc(); push_acc(1, 1, 1, 6); drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 6);
    cyc(); push_acc(0, 1, 1, 3); push_rd(0, 3); drive(1, 0, 1, 1, 1, 3, 0, 0, 0, 0);
    cyc(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("d_r0_data", int'(r0_readdata), 3);

    // Continuous reads from both: last grant was r0, so order is 1,0,1,0,...
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i % 2 == 0) begin
        push_acc(1, 0, 1, 0); push_rd(1, 3);
      end else begin
        push_acc(0, 0, 0, 0); push_rd(0, 5);
      end
      drive(1, 0, 1, 0, 0, 0, 1, 0, 1, 0);
      if (i > 0) check("c_rdv_nogap", int'(r0_readdatavalid | r1_readdatavalid), 1);
    end

    // One-cycle stall with both active: grant must not advance.
    cyc(); drive(1, 1, 1, 0, 0, 0, 1, 0, 1, 0);
    check("e_stall_r0_wait", int'(r0_waitrequest), 1);
    check("e_stall_r1_wait", int'(r1_waitrequest), 1);
    cyc(); push_acc(1, 0, 1, 0); push_rd(1, 3); drive(1, 0, 1, 0, 0, 0, 1, 0, 1, 0);
    check("e_after_r0_wait", int'(r0_waitrequest), 1);
    cyc(); push_acc(0, 0, 0, 0); push_rd(0, 5); drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // r1 read accepted, then reset: its readdatavalid must never appear.
    cyc(); push_acc(1, 0, 1, 0); drive(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("f_rst_r1_rdv", int'(r1_readdatavalid), 0);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); push_acc(0, 1, 0, 2); drive(1, 0, 0, 1, 0, 2, 0, 1, 1, 4);
    cyc(); push_acc(1, 1, 1, 4); drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 4);
    cyc(); push_acc(0, 0, 0, 0); push_rd(0, 2); drive(1, 0, 1, 0, 0, 0, 1, 0, 1, 0);
    cyc(); push_acc(1, 0, 1, 0); push_rd(1, 4); drive(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("hold_wr_addr", int'(wr_address), 1);
    check("hold_rd_addr", int'(rd0_address), 1);
    cyc(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    check("acc_q_drained", acc_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_64_to_32_bits_dfa_state_arbiter.md
LCD_64_TO_32_BITS_DFA_STATE_ARBITER -- requirements
Module: lcd_64_to_32_bits_dfa_state_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 1, shall set the state RAM address width.
REQ-002 Parameter DATA_WIDTH, default 3, shall set the state word width.
REQ-003 Parameter RD_LATENCY, default 1, shall set the clocks from a RAM read address to valid RAM read data; legal range 1-4.
REQ-004 clk  in  1  single clock; all logic shall be on its rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 rN_address  in  ADDRESS_WIDTH  requester N command address, N = 0, 1.
REQ-007 rN_writedata  in  DATA_WIDTH  requester N write data.
REQ-008 rN_write  in  1  requester N write command.
REQ-009 rN_read  in  1  requester N read command.
REQ-010 rN_waitrequest  out  1  high means requester N's command is not accepted this cycle.
REQ-011 rN_readdata  out  DATA_WIDTH  read data returned to requester N.
REQ-012 rN_readdatavalid  out  1  one-cycle strobe qualifying rN_readdata.
REQ-013 wr_address, wr_writedata, wr_write  out  ADDRESS_WIDTH/DATA_WIDTH/1  state RAM write port.
REQ-014 wr_waitrequest  in  1  state RAM busy, including the post-reset clear.
REQ-015 rd0_address  out  ADDRESS_WIDTH  state RAM read address.
REQ-016 rd0_readdata  in  DATA_WIDTH  state RAM read data, valid RD_LATENCY clocks after the address.

Function
REQ-017 A requester shall be active when rN_read or rN_write is high; it may assert both, meaning read old value and write new value at one address in one command.
REQ-018 The arbiter shall grant at most one requester per cycle, combinationally from the active requests and the last_grant register.
REQ-019 Round-robin: with both requesters active, grant shall go to the requester other than last_grant; with one active, grant shall go to that one.
REQ-020 A command shall be accepted when granted and wr_waitrequest is low; rN_waitrequest = rN active AND NOT accepted; rN_waitrequest shall be 0 when rN is idle.
REQ-021 While wr_waitrequest is high, no command shall be accepted (reads included), and wr_write and the read pipeline input shall be 0.
REQ-022 last_grant shall update to the accepted requester only on acceptance; a stalled cycle shall not change it.
REQ-023 On acceptance the granted rN_address shall drive wr_address and rd0_address, and rN_writedata shall drive wr_writedata in the same cycle.
REQ-024 wr_write shall equal acceptance AND the granted rN_write.
REQ-025 When idle, rd0_address and wr_address shall hold the last accepted address, and wr_write shall be 0.
REQ-026 A RD_LATENCY-deep shift register of {valid, id} shall record each accepted read; valid = accepted AND granted rN_read.
REQ-027 At the shift-register output, rN_readdatavalid shall be high for exactly one cycle when valid is set and id equals N.
REQ-028 Readdata timing: rN_readdata shall be rd0_readdata, unregistered, so an accepted read returns exactly RD_LATENCY clocks after acceptance.
REQ-029 Throughput: one command per cycle sustained; with both requesters continuously active, grants shall alternate 0,1,0,1.
REQ-030 Read-after-write hazards shall be resolved by the RAM's lookahead bypass; the arbiter shall add no hazard stall.
REQ-031 Starvation: an active requester shall be accepted within 2 non-busy cycles.

Reset
REQ-032 During reset_n low at a clock edge, the following shall clear:
  - last_grant to 1, so r0 wins the first contention;
  - every shift-register valid bit to 0;
  - the held address to 0.
REQ-033 Outputs during reset:
  - rN_readdatavalid shall be 0;
  - wr_write shall be 0;
  - rN_waitrequest shall be 1 for active requesters.
REQ-034 A reset mid-operation shall discard in-flight reads with no readdatavalid issued for them; accepted writes are not retracted.

Verification
REQ-035 Reset, then release while wr_waitrequest stays high 2 cycles with r0_read=1 -> r0_waitrequest=1 for those cycles, wr_write=0, accept on the first cycle wr_waitrequest=0.
REQ-036 Both active, r0 write addr0 data 5, r1 read addr0 -> r0 accepted first with wr_write=1, wr_writedata=5; r1 accepted next cycle; r1_readdatavalid=1 with r1_readdata=5 exactly RD_LATENCY cycles later.
REQ-037 Both requesters issue reads continuously for 10 cycles -> grant order 0,1,0,1,...; 5 accepts each; readdatavalid strobes alternate with no gaps.
REQ-038 r0 and r1 both active, wr_waitrequest pulsed high 1 cycle -> no accept that cycle, last_grant unchanged, the same requester is accepted after the stall.
REQ-039 r0 asserts read and write together, addr1, data 3, with prior content 6 -> r0_readdata=6 or 3 per RAM lookahead at RD_LATENCY, and a single accept with wr_write=1.
REQ-040 Accept an r1 read, then assert reset_n=0 the next cycle -> r1_readdatavalid never asserts; after release the first contention grants r0.
